// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 systolic multiplier: element format,
// matrix size and the result-drain state encoding.
package systolic_pkg;
   localparam int WIDTH    = 8;
   localparam int N        = 3;

   localparam int SIGN_BIT = 7;
   localparam int EXP_MSB  = 6;
   localparam int EXP_LSB  = 4;
   localparam int MAN_MSB  = 3;
   localparam int MAN_LSB  = 0;
   localparam int EXP_BIAS = 3;

   typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/fp8_classify.sv
// Combinational zero/sign flags for one 8-bit float element
// (1 sign, 3 exponent, 4 mantissa).
module fp8_classify
   import systolic_pkg::*;
(
   input  logic [WIDTH-1:0] elem_i,
   output logic             is_zero,
   output logic             is_neg
);

   // -0 counts as zero here; the sign is reported separately
   assign is_zero = (elem_i[EXP_MSB:EXP_LSB] == '0) && (elem_i[MAN_MSB:MAN_LSB] == '0);
   assign is_neg  = elem_i[SIGN_BIT];

endmodule

// File: rtl/systolic_result_reader.sv
// Result drain: snapshots the NxN array output on a done rising edge and
// streams it row-major over valid/ready with row/col/last/zero/neg tags.
module systolic_result_reader #(
   parameter int WIDTH = systolic_pkg::WIDTH,
   parameter int N     = systolic_pkg::N
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 done_in,
   input  logic [N*N*WIDTH-1:0] m_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [1:0]           out_row,
   output logic [1:0]           out_col,
   output logic                 out_last,
   output logic                 out_zero,
   output logic                 out_neg,
   output logic                 busy,
   output logic                 overrun
);
   import systolic_pkg::*;

   localparam int              KW      = $clog2(N*N);
   localparam logic [KW-1:0]   LAST_K  = KW'(N*N-1);
   localparam logic [1:0]      LAST_RC = 2'(N-1);

   state_e           state_q, state_d;
   logic             done_q;
   logic [KW-1:0]    k_q, k_d;
   logic [1:0]       row_q, row_d;
   logic [1:0]       col_q, col_d;
   logic             overrun_q, overrun_d;
   logic [WIDTH-1:0] snap_q [N*N];

   logic rise, hs, at_last, capture;

   assign rise    = done_in & ~done_q;
   assign hs      = out_valid & out_ready;
   assign at_last = (k_q == LAST_K);
   // A rise landing on the final handshake restarts instead of being dropped
   assign capture = rise & ((state_q == IDLE) | (hs & at_last));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         k_q       <= '0;
         row_q     <= '0;
         col_q     <= '0;
         overrun_q <= 1'b0;
         for (int i = 0; i < N*N; i++) snap_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         done_q    <= done_in;
         k_q       <= k_d;
         row_q     <= row_d;
         col_q     <= col_d;
         overrun_q <= overrun_d;
         if (capture) begin
            for (int i = 0; i < N*N; i++) snap_q[i] <= m_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = STREAM;
         STREAM:  if (hs && at_last && !rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Row/col run alongside k so no divide or modulo is needed
   always_comb begin
      k_d   = k_q;
      row_d = row_q;
      col_d = col_q;
      if (capture || (hs && at_last)) begin
         k_d   = '0;
         row_d = '0;
         col_d = '0;
      end else if (hs) begin
         k_d = k_q + 1'b1;
         if (col_q == LAST_RC) begin
            col_d = '0;
            row_d = row_q + 2'd1;
         end else begin
            col_d = col_q + 2'd1;
         end
      end
   end

   assign overrun_d = overrun_q | (rise & (state_q == STREAM) & ~(hs & at_last));

   always_comb begin
      out_valid = (state_q == STREAM);
      busy      = (state_q == STREAM);
      out_last  = (state_q == STREAM) & at_last;
   end

   assign out_data = snap_q[k_q];
   assign out_row  = row_q;
   assign out_col  = col_q;
   assign overrun  = overrun_q;

   fp8_classify u_classify (
      .elem_i  (out_data),
      .is_zero (out_zero),
      .is_neg  (out_neg)
   );

endmodule

// File: tb/tb_systolic_result_reader.sv
// Scoreboard bench for systolic_result_reader: stimulus queues expected
// beats, a negedge monitor pops and compares on every accepted beat.
module tb_systolic_result_reader;

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] r;
      logic [1:0] c;
      logic       l;
      logic       z;
      logic       n;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        done_in;
   logic [71:0] m_in;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_row;
   logic [1:0]  out_col;
   logic        out_last;
   logic        out_zero;
   logic        out_neg;
   logic        busy;
   logic        overrun;

   int    tests = 0;
   int    fails = 0;
   int    nbeats = 0;
   beat_t exp_q[$];

   systolic_result_reader dut (
      .clk       (clk),
      .reset     (reset),
      .done_in   (done_in),
      .m_in      (m_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .out_zero  (out_zero),
      .out_neg   (out_neg),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_mat(input logic [71:0] mat);
      beat_t b;
      for (int i = 0; i < 9; i++) begin
         b.d = mat[i*8 +: 8];
         b.r = 2'(i / 3);
         b.c = 2'(i % 3);
         b.l = (i == 8);
         b.z = (b.d[6:0] == 7'd0);
         b.n = b.d[7];
         exp_q.push_back(b);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"},   32'(out_valid), 32'd0);
      chk({tag, "_data"},    32'(out_data),  32'd0);
      chk({tag, "_zero"},    32'(out_zero),  32'd1);
      chk({tag, "_neg"},     32'(out_neg),   32'd0);
      chk({tag, "_last"},    32'(out_last),  32'd0);
      chk({tag, "_row"},     32'(out_row),   32'd0);
      chk({tag, "_col"},     32'(out_col),   32'd0);
      chk({tag, "_busy"},    32'(busy),      32'd0);
      chk({tag, "_overrun"}, 32'(overrun),   32'd0);
   endtask

   task automatic drain(input bit bp, input int max);
      logic [3:0] pat = 4'b1001;
      bit ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(posedge clk);
         #1;
         if (bp) out_ready = pat[i % 4];
         if (exp_q.size() == 0 && !out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("drain_complete", 32'(ok), 32'd1);
   endtask

   // Monitor: stability across stalls, then scoreboard compare per accepted beat
   logic       held = 1'b0;
   logic [7:0] h_data;
   logic [1:0] h_row, h_col;
   always @(negedge clk) begin
      beat_t e;
      if (out_valid && held) begin
         chk("stall_data", 32'(out_data), 32'(h_data));
         chk("stall_row",  32'(out_row),  32'(h_row));
         chk("stall_col",  32'(out_col),  32'(h_col));
      end
      held   = out_valid && !out_ready;
      h_data = out_data;
      h_row  = out_row;
      h_col  = out_col;
      if (!reset && out_valid && out_ready) begin
         nbeats++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got data %0h, no beat expected at %0t", out_data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(e.d));
            chk("beat_row",  32'(out_row),  32'(e.r));
            chk("beat_col",  32'(out_col),  32'(e.c));
            chk("beat_last", 32'(out_last), 32'(e.l));
            chk("beat_zero", 32'(out_zero), 32'(e.z));
            chk("beat_neg",  32'(out_neg),  32'(e.n));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   localparam logic [71:0] SET3  = {8'hA0, 8'h38, 8'hA0, 8'h40, 8'hB0, 8'h40, 8'hA0, 8'h38, 8'hA0};
   localparam logic [71:0] ALL30 = {9{8'h30}};
   localparam logic [71:0] SEQ   = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
   localparam logic [71:0] NEWB  = {8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h00, 8'h80};

   initial begin
      reset     = 1'b1;
      done_in   = 1'b0;
      m_in      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      reset = 1'b0;

      // Idle with no done pulse
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_valid", 32'(out_valid), 32'd0);
      end
      chk("idle_overrun", 32'(overrun),  32'd0);
      chk("idle_zero",    32'(out_zero), 32'd1);

      // Test set 3 result at full throughput
      m_in      = SET3;
      out_ready = 1'b1;
      push_mat(SET3);
      done_in   = 1'b1;
      @(posedge clk);
      #1;
      done_in = 1'b0;
      chk("latency_busy", 32'(busy), 32'd1);
      drain(1'b0, 30);
      @(negedge clk);
      chk("set3_valid_after", 32'(out_valid), 32'd0);
      chk("set3_overrun",     32'(overrun),   32'd0);

      // Backpressure, snapshot immune to later m_in changes
      nbeats  = 0;
      m_in    = ALL30;
      push_mat(ALL30);
      done_in = 1'b1;
      @(posedge clk);
      #1;
      done_in = 1'b0;
      m_in    = '0;
      drain(1'b1, 60);
      chk("bp_beats", 32'(nbeats), 32'd9);
      out_ready = 1'b1;

      // Overrun: second rise during beat 4 is dropped
      m_in = SEQ;
      push_mat(SEQ);
      done_in = 1'b1;
      @(posedge clk);
      #1;
      done_in = 1'b0;
      m_in    = {9{8'hFF}};
      repeat (3) @(posedge clk);
      #1;
      done_in = 1'b1;
      @(posedge clk);
      #1;
      done_in = 1'b0;
      drain(1'b0, 30);
      chk("overrun_set", 32'(overrun), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("overrun_sticky", 32'(overrun), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("overrun_cleared", 32'(overrun), 32'd0);

      // Same-cycle restart on the final handshake
      m_in = SEQ;
      push_mat(SEQ);
      push_mat(NEWB);
      done_in = 1'b1;
      @(posedge clk);
      #1;
      done_in = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      done_in = 1'b1;
      m_in    = NEWB;
      @(posedge clk);
      #1;
      done_in = 1'b0;
      chk("restart_valid", 32'(out_valid), 32'd1);
      chk("restart_row",   32'(out_row),   32'd0);
      chk("restart_col",   32'(out_col),   32'd0);
      drain(1'b0, 30);
      chk("restart_overrun", 32'(overrun), 32'd0);

      // Reset at beat 5 while done_in stays high
      m_in = SET3;
      push_mat(SET3);
      done_in = 1'b1;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("midreset");
      reset     = 1'b0;
      exp_q.delete();
      push_mat(SET3);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("recapture_valid", 32'(out_valid), 32'd1);
      chk("recapture_row",   32'(out_row),   32'd0);
      chk("recapture_col",   32'(out_col),   32'd0);
      drain(1'b0, 30);
      repeat (4) @(posedge clk);
      #1;
      chk("held_done_single_capture", 32'(out_valid), 32'd0);
      done_in = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/systolic_result_reader.md
# systolic_result_reader

Output-side drain for the 3x3 systolic matrix multiplier. The block detects completion of a multiply on the array's `done` level and snapshots all nine 8-bit result elements `M1..M9` in one cycle. It then streams them row-major over a valid/ready interface, one element per accepted beat, tagged with row/column, last, zero and sign flags. It frees the array to be reset and restarted while results drain, and it is the consumer counterpart to the array's operand inputs.

## Interface

Parameters:

- `WIDTH`, 8: element width; 8-bit float, 1 sign, 3 exponent (bias 3), 4 mantissa, hidden 1.
- `N`, 3: matrix dimension; `N*N` elements per result.

Ports (one clock; reset is synchronous and active-high):

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `done_in`  in  1  array completion level; a rising edge marks a new result.
- `m_in`  in  `N*N*WIDTH`  packed results; `M1` in bits [7:0], `M9` in the MSBs.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  `WIDTH`  current element.
- `out_row`  out  2  row index 0..N-1.
- `out_col`  out  2  column index 0..N-1.
- `out_last`  out  1  high on element `N*N-1`.
- `out_zero`  out  1  exponent and mantissa fields of `out_data` are all 0.
- `out_neg`  out  1  sign bit of `out_data`; raw bit, so it is set for -0 too.
- `busy`  out  1  state is STREAM.
- `overrun`  out  1  sticky; set on a `done_in` rising edge that is dropped.

## Operation

- States:
  - IDLE: `out_valid` = 0.
  - STREAM: `out_valid` = 1, element index `k` runs 0..N*N-1.
- Edge detection uses register `done_q`, which follows `done_in` every cycle. `rise = done_in & ~done_q`.
- IDLE with `rise`: capture `m_in` into the snapshot, set `k` = 0, go to STREAM.
- STREAM without a handshake: hold `k`. `out_data` and the flags stay stable.
- STREAM with a handshake (`out_valid & out_ready`):
  - if `k` < N*N-1: `k` increments.
  - if `k` = N*N-1: go to IDLE.
- Outputs during STREAM:
  - `out_data` = snapshot element `k`.
  - `out_row` = k / N and `out_col` = k % N, taken from separate row/col counters; no divider.
  - `out_last` = (k == N*N-1).
- Simultaneous final handshake and `rise` in the same cycle: capture the new snapshot, go to STREAM with `k` = 0. `overrun` is not set.
- `rise` in STREAM that is not the final-handshake cycle: the event is dropped, the snapshot is untouched, and `overrun` is set to 1 until reset.
- `done_in` held high: produces only one capture. A new capture needs `done_in` to fall and rise again.
- `m_in` is sampled only on the capture cycle. Later changes never affect the stream in progress.
- Arithmetic is pass-through; no value conversion.
  - `out_zero` = (out_data[6:0] == 0).
  - `out_neg` = out_data[7].

## Timing

- Reset values: state IDLE, `done_q` 0, `k` 0, snapshot 0, `overrun` 0. Hence `out_valid`, `out_last`, `busy`, `out_neg` are 0, `out_data` is 0, `out_zero` is 1, and row/col are 0.
- Reset mid-stream: the next cycle is IDLE with all outputs at reset values; no beat completes. `done_q` is cleared, so `done_in` still high after reset counts as a new rise.
- Latency: a `rise` sampled at edge t gives `out_valid` = 1 after edge t; the first beat is offered in cycle t+1.
- Throughput: one element per cycle with `out_ready` held high. A full 3x3 result takes 9 cycles from the first valid.
- After the last handshake at edge t+9, `out_valid` = 0 from then on, unless a same-cycle `rise` restarts the stream.
- All outputs are registered or decoded only from registered state; there is no combinational path from `out_ready` or `done_in` to any output.

## Structure

- Shared package `systolic_pkg`:
  - `WIDTH`, `N`.
  - float field positions: `SIGN_BIT`=7, `EXP_MSB`=6, `EXP_LSB`=4, `MAN_MSB`=3, `MAN_LSB`=0, `EXP_BIAS`=3.
  - state enum {IDLE, STREAM}.
- One sub-module, `fp8_classify`: combinational; input `WIDTH`-bit element, outputs `is_zero` and `is_neg`. It is reused later by the operand side.
- Top level: edge detector, snapshot register array, index/row/col counters, FSM.

## Test plan

- Reset then idle: no `done_in` pulse for 20 cycles -> `out_valid`=0 throughout, `overrun`=0, `out_zero`=1.
- Test-set-3 result (C = -0.5, 1.5, -0.5 / 2, -1, 2 / -0.5, 1.5, -0.5) on `m_in`, `done_in` rises, `out_ready`=1:
  - beats are 0xA0, 0x38, 0xA0, 0x40, 0xB0, 0x40, 0xA0, 0x38, 0xA0.
  - row/col run (0,0)..(2,2).
  - `out_neg` = 1,0,1,0,1,0,1,0,1.
  - `out_last` only on beat 9; `out_valid` drops the cycle after.
- Backpressure: all elements 0x30, `out_ready` toggled 1,0,0,1,... -> exactly 9 beats of 0x30. `out_data`, row and col stay stable across stalls. `m_in` changed to 0x00 after capture has no effect.
- Overrun: second `done_in` rise at beat 4 -> stream continues with the original data, `overrun`=1 and held until reset.
- Same-cycle restart: `rise` coincides with the last handshake -> `out_valid` stays 1, the next beat is element 0 of the new snapshot, `overrun`=0.
- Reset at beat 5 with `done_in` held high -> outputs return to reset values. When `reset` deasserts, the next edge recaptures (rise seen) and streaming restarts at (0,0).
